// File: rtl/grid_io_param_tile.sv
// grid_io_param_tile: IO tile with a serial config chain, a commit-protected active config, and isolatable pads
// Ports: prog_clk/pReset are the clock and sync reset. ccff_head/ccff_tail are the serial chain in/out.
// cfg_shift_en and cfg_commit control loading. cfg_done/cfg_err report load status.
// IO_ISOL_N=0 isolates the pads. SOC_IN/SOC_OUT/SOC_DIR face the pads; io_outpad/io_inpad face the fabric.
module grid_io_param_tile #(
  parameter int NUM_IO = 4
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              IO_ISOL_N,
  input  logic              ccff_head,
  input  logic              cfg_shift_en,
  input  logic              cfg_commit,
  input  logic [0:NUM_IO-1] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
  output logic [0:NUM_IO-1] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
  output logic [0:NUM_IO-1] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
  input  logic [0:NUM_IO-1] io_outpad,
  output logic [0:NUM_IO-1] io_inpad,
  output logic              ccff_tail,
  output logic              cfg_done,
  output logic              cfg_err
);
  localparam int CHAIN_LEN = 2 * NUM_IO;
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CHAIN_LEN);
  logic [0:CHAIN_LEN-1] chain, act;
  logic [CNT_W-1:0] cnt, cnt_sh;
  logic full, take;
  always_comb begin
    full = cnt == FULL;
    take = cfg_commit && full;
    cnt_sh = cfg_shift_en && !full ? cnt + CNT_W'(1) : cnt;
  end
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      chain <= '0;
      act <= '0;
      cnt <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (cfg_shift_en) chain <= {ccff_head, chain[0:CHAIN_LEN-2]};
      if (take) act <= chain;
      // an accepted commit restarts the count; a same-cycle shift is bit 1 of the next load
      cnt <= take ? CNT_W'(cfg_shift_en) : cnt_sh;
      if ((cfg_shift_en && full && !take) || (cfg_commit && !full)) cfg_err <= 1'b1;
    end
  end
  always_comb begin
    ccff_tail = chain[CHAIN_LEN-1];
    cfg_done = full;
    for (int i = 0; i < NUM_IO; i++) begin
      gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[i] = IO_ISOL_N ? act[2*i] : 1'b1;
      gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[i] = IO_ISOL_N && !act[2*i] ? io_outpad[i] ^ act[2*i+1] : 1'b0;
      io_inpad[i] = IO_ISOL_N && act[2*i] ? gfpga_pad_EMBEDDED_IO_HD_SOC_IN[i] ^ act[2*i+1] : 1'b0;
    end
  end
endmodule
